// File: rtl/keypad_scan_if.sv
// Keypad matrix and decoded-key signals; master is the scanner, slave is the matrix/lock side.
interface keypad_scan_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [9:0] tenkey;
  logic       close;
  logic       clr;

  modport master (output row, output tenkey, output close, output clr, input col);
  modport slave  (input row, input tenkey, input close, input clr, output col);
endinterface

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: row-at-a-time drive, frame-level debounce, one-hot digit and '#'/'*' pulses.
// Outputs update one cycle after the frame end on which the debounce count is reached.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEB_CNT  = 3
) (
  input  logic          ck,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int unsigned DW  = 8;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEB_CNT);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ridx_q, ridx_d;
  logic [11:0]   raw_q, raw_d;
  logic [11:0]   prev_q, prev_d;
  logic [11:0]   acc_q, acc_d;
  logic [3:0]    stab_q, stab_d;
  logic [9:0]    tenkey_q, tenkey_d;
  logic          close_q, close_d;
  logic          clr_q, clr_d;

  logic          dwell_end;
  logic          frame_end;
  logic [11:0]   frame_raw;
  logic [11:0]   cand;
  logic          one_key;

  always_comb begin
    dwell_end = (div_q == DWELL_LAST);
    frame_end = dwell_end && (ridx_q == 2'd3);
    div_d     = dwell_end ? '0 : div_q + 8'd1;
    ridx_d    = dwell_end ? ridx_q + 2'd1 : ridx_q;

    raw_d = raw_q;
    if (dwell_end) begin
      case (ridx_q)
        2'd0:    raw_d[2:0]  = ~kp.col;
        2'd1:    raw_d[5:3]  = ~kp.col;
        2'd2:    raw_d[8:6]  = ~kp.col;
        default: raw_d[11:9] = ~kp.col;
      endcase
    end
    // Row 3 is sampled on the frame-end cycle itself, so splice it in directly.
    frame_raw = {~kp.col, raw_q[8:0]};

    stab_d = stab_q;
    prev_d = prev_q;
    if (frame_end) begin
      if (frame_raw == prev_q) begin
        if (stab_q < DEB) stab_d = stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
        prev_d = frame_raw;
      end
    end

    one_key  = (frame_raw != '0) && ((frame_raw & (frame_raw - 12'd1)) == '0);
    cand     = '0;
    acc_d    = acc_q;
    tenkey_d = tenkey_q;
    close_d  = 1'b0;
    clr_d    = 1'b0;
    if (frame_end && (stab_d == DEB)) begin
      // Multi-press collapses to "no key" rather than keeping the old key.
      cand     = one_key ? frame_raw : '0;
      acc_d    = cand;
      tenkey_d = {cand[8:0], cand[10]};
      close_d  = cand[11] & ~acc_q[11];
      clr_d    = cand[9]  & ~acc_q[9];
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      ridx_q   <= '0;
      raw_q    <= '0;
      prev_q   <= '0;
      acc_q    <= '0;
      stab_q   <= '0;
      tenkey_q <= '0;
      close_q  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      ridx_q   <= ridx_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      acc_q    <= acc_d;
      stab_q   <= stab_d;
      tenkey_q <= tenkey_d;
      close_q  <= close_d;
      clr_q    <= clr_d;
    end
  end

  assign kp.row    = ~(4'b0001 << ridx_q);
  assign kp.tenkey = tenkey_q;
  assign kp.close  = close_q;
  assign kp.clr    = clr_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan with a frame-history reference model and event scoreboard.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DC = 3;

  typedef struct {
    int         cyc;
    logic [9:0] tk;
    logic       cl;
    logic       cr;
  } ev_t;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          close_cnt = 0;
  int          clr_cnt = 0;

  ev_t         exp_q[$];
  logic [11:0] frames[$];
  logic [11:0] cur_frame = '0;
  int          model_key = -1;
  int          digit_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 0, -1};

  keypad_scan_if kif();

  keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DC)) dut (
    .ck    (ck),
    .reset (rst_n),
    .kp    (kif)
  );

  initial forever #5 ck = ~ck;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kif.col = 3'b111;
    for (int r = 0; r < 4; r++)
      if (!kif.row[r]) kif.col = kif.col & ~pressed[3*r +: 3];
  end

  function automatic int decode(input logic [11:0] f);
    if ($countones(f) != 1) return -1;
    for (int b = 0; b < 12; b++) if (f[b]) return b;
    return -1;
  endfunction

  function automatic logic [9:0] tk_of(input int key);
    logic [9:0] one = 10'd1;
    if (key < 0) return '0;
    if (digit_of[key] < 0) return '0;
    return one << digit_of[key];
  endfunction

  function automatic bit frames_agree();
    if (frames.size() != DC) return 1'b0;
    foreach (frames[i]) if (frames[i] != frames[0]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: a key state is accepted when the last DC complete frames are identical.
  always @(posedge ck or negedge rst_n) begin
    int  n;
    int  r;
    int  k;
    ev_t e;
    if (!rst_n) begin
      cyc = 0;
      frames.delete();
      cur_frame = '0;
      model_key = -1;
    end else begin
      n = cyc;
      if (n % SD == SD - 1) begin
        r = (n / SD) % 4;
        cur_frame[3*r +: 3] = pressed[3*r +: 3];
        if (r == 3) begin
          frames.push_back(cur_frame);
          if (frames.size() > DC) void'(frames.pop_front());
          if (frames_agree()) begin
            k = decode(cur_frame);
            if (k != model_key) begin
              e.cyc = n + 1;
              e.tk  = tk_of(k);
              e.cl  = (k == 11);
              e.cr  = (k == 9);
              if (e.tk != tk_of(model_key) || e.cl || e.cr) exp_q.push_back(e);
              model_key = k;
            end
          end
        end
      end
      cyc = n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every visible output event is matched against the next expected one.
  logic [9:0] last_tk = '0;
  always @(negedge ck) begin
    logic [3:0] one4;
    logic [3:0] exp_row;
    ev_t        e;
    one4 = 4'b0001;
    if (!rst_n) begin
      last_tk = '0;
    end else begin
      exp_row = ~(one4 << ((cyc / SD) % 4));
      checks++;
      if (kif.row !== exp_row) begin
        errors++;
        $display("FAIL row cyc=%0d: got %b expected %b", cyc, kif.row, exp_row);
      end
      checks++;
      if ($countones(kif.tenkey) > 1 || (kif.close && kif.clr) ||
          ((kif.close || kif.clr) && kif.tenkey != '0)) begin
        errors++;
        $display("FAIL exclusivity cyc=%0d: tenkey=%b close=%b clr=%b", cyc, kif.tenkey, kif.close, kif.clr);
      end
      if (kif.tenkey != last_tk || kif.close || kif.clr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: got tenkey=%b close=%b clr=%b, no event expected",
                   cyc, kif.tenkey, kif.close, kif.clr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.tk !== kif.tenkey || e.cl !== kif.close || e.cr !== kif.clr) begin
            errors++;
            $display("FAIL event: got cyc=%0d tenkey=%b close=%b clr=%b expected cyc=%0d tenkey=%b close=%b clr=%b",
                     cyc, kif.tenkey, kif.close, kif.clr, e.cyc, e.tk, e.cl, e.cr);
          end
        end
      end
      if (kif.close) close_cnt++;
      if (kif.clr) clr_cnt++;
      last_tk = kif.tenkey;
    end
  end

  task automatic hold(input logic [11:0] pat, input int n);
    pressed = pat;
    repeat (n) @(negedge ck);
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_row"},    32'(kif.row),    32'b1110);
    chk({tag, "_tenkey"}, 32'(kif.tenkey), 32'd0);
    chk({tag, "_close"},  32'(kif.close),  32'd0);
    chk({tag, "_clr"},    32'(kif.clr),    32'd0);
  endtask

  initial begin
    int c0;
    int r0;
    int kind;
    int k1;
    int k2;
    logic [11:0] one12;
    logic [11:0] p;
    one12 = 12'd1;

    repeat (3) @(negedge ck);
    #1 reset_outputs_chk("reset");
    @(negedge ck);
    #2 rst_n = 1'b1;

    hold('0, 40);
    chk("idle_tenkey", 32'(kif.tenkey), 32'd0);

    hold(one12 << 7, 100);
    chk("hold8_tenkey", 32'(kif.tenkey), 32'b0100000000);
    hold('0, 70);
    chk("rel8_tenkey", 32'(kif.tenkey), 32'd0);

    c0 = close_cnt;
    r0 = clr_cnt;
    hold(one12 << 11, 100);
    chk("hash_close_pulses", 32'(close_cnt - c0), 32'd1);
    chk("hash_clr_pulses",   32'(clr_cnt - r0),   32'd0);
    chk("hash_tenkey",       32'(kif.tenkey),     32'd0);
    hold('0, 70);
    chk("hash_release_pulses", 32'(close_cnt - c0), 32'd1);

    c0 = close_cnt;
    r0 = clr_cnt;
    hold((one12 << 2) | (one12 << 5), 80);
    chk("multi_tenkey", 32'(kif.tenkey), 32'd0);
    chk("multi_pulses", 32'(close_cnt - c0 + clr_cnt - r0), 32'd0);
    hold(one12 << 2, 70);
    chk("three_tenkey", 32'(kif.tenkey), 32'b0000001000);
    hold('0, 70);

    for (int i = 0; i < 2; i++) begin
      hold(one12 << 4, 10);
      hold('0, 10);
    end
    chk("bounce5_tenkey", 32'(kif.tenkey), 32'd0);
    hold(one12 << 4, 70);
    chk("stable5_tenkey", 32'(kif.tenkey), 32'b0000100000);
    hold('0, 70);

    hold(one12 << 8, 100);
    chk("hold9_tenkey", 32'(kif.tenkey), 32'b1000000000);
    #2 rst_n = 1'b0;
    #1 reset_outputs_chk("midpress_reset");
    repeat (3) @(negedge ck);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge ck);
    chk("post_reset_no_early_key", 32'(kif.tenkey), 32'd0);
    repeat (30) @(negedge ck);
    chk("post_reset_key9", 32'(kif.tenkey), 32'b1000000000);
    hold('0, 70);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      k1 = $urandom_range(0, 11);
      k2 = $urandom_range(0, 11);
      case (kind)
        0: p = '0;
        1: p = one12 << k1;
        2: p = (one12 << k1) | (one12 << k2);
        default: begin
          p = one12 << k1;
          for (int j = 0; j < 4; j++) begin
            hold(p, $urandom_range(1, 12));
            hold('0, $urandom_range(1, 12));
          end
        end
      endcase
      hold(p, $urandom_range(10, 90));
    end

    hold('0, 100);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each row is driven (dwell), range 2..255.
REQ-002 Parameter DEB_CNT, default 3: consecutive identical frames required to accept a new key state, range 1..15.
REQ-003 ck  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 row  output  4  matrix row drive, active-low, exactly one bit low at any time.
REQ-006 col  input  3  matrix column sense, active-low (externally pulled up); treated as synchronous to ck.
REQ-007 tenkey  output  10  one-hot digit code, bit n = digit n held down and debounced; feeds the lock's tenkey input.
REQ-008 close  output  1  single-cycle pulse on accepted press of '#'; feeds the lock's close input.
REQ-009 clr  output  1  single-cycle pulse on accepted press of '*'.

Function
REQ-010 Key map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.
REQ-011 Scan order r0,r1,r2,r3, repeating; row[i] = 0 selects row i; the row changes after SCAN_DIV cycles; frame = 4*SCAN_DIV cycles.
REQ-012 col is sampled on the last cycle of each row's dwell into a 12-bit raw frame vector, bit = 3*row+col, 1 = pressed.
REQ-013 At frame end: if raw == previous frame raw, stable counter increments (saturating at DEB_CNT); otherwise it reloads to 1 and previous raw is updated.
REQ-014 When stable counter reaches DEB_CNT, the accepted code is updated from raw on the cycle after frame end; no update otherwise.
REQ-015 Accepted code with exactly one bit set = that key; zero bits or two or more bits = no key (multi-press rejected, not latched).
REQ-016 tenkey is registered: one-hot of accepted digit key, else 10'b0; it stays asserted for as long as the key is accepted.
REQ-017 close pulses high for exactly one cycle when the accepted key changes to '#'; clr likewise for '*'; no repeat while held.
REQ-018 Direct transition from one accepted key to another (no release frame) updates tenkey in the same cycle and fires close/clr if the new key is '#'/'*'.
REQ-019 Bounce: any raw change shorter than DEB_CNT frames shall not alter tenkey, close or clr.
REQ-020 Latency: a clean press stable from the start of frame k is visible on tenkey one cycle after the end of frame k+DEB_CNT-1, i.e. at most (DEB_CNT+1)*4*SCAN_DIV+1 cycles after onset.
REQ-021 Release follows the same debounce rule; tenkey returns to 0, and no pulse fires on release.
REQ-022 At most one tenkey bit is high in any cycle; close and clr are never high together, and never high with a tenkey bit.

Reset
REQ-023 While reset = 0: row = 4'b1110, tenkey = 0, close = 0, clr = 0, dwell and stable counters = 0, raw/previous/accepted codes = no key.
REQ-024 Reset asserted mid-scan or mid-press takes effect immediately (asynchronous), without waiting for a clock edge.
REQ-025 After release, scanning restarts at r0 on the first rising edge, and a held key needs a full debounce from scratch.

Verification (SCAN_DIV=4, DEB_CNT=3, frame = 16 cycles)
REQ-026 Idle, col = 3'b111 -> row cycles 1110,1101,1011,0111 every 4 cycles; tenkey = 0; close = clr = 0 throughout.
REQ-027 Hold '8' (col[1] low during r2) for 100 cycles -> tenkey = 10'b0100000000 within 65 cycles; it drops to 0 within 65 cycles of release.
REQ-028 Hold '#' for 100 cycles -> close high for exactly one cycle; tenkey = 0; clr = 0.
REQ-029 Hold '3' and '6' together -> tenkey stays 0 with no pulses; release '6' while keeping '3' -> tenkey = 10'b0000001000.
REQ-030 Press '5' bouncing (toggling every 10 cycles for 40 cycles), then stable -> no output during the bounce, then tenkey = 10'b0000100000 once stable for 3 frames.
REQ-031 Assert reset mid-press of '9' -> all outputs 0 and row = 1110 at once; after release, tenkey returns only after a full debounce.
